// File: rtl/pcpi_pkg.sv
// pcpi_pkg -- shared definitions for the PCPI mul/div dispatcher.
//   OPCODE_OP / FUNCT7_MULDIV : RV32M instruction match fields
//   pcpi_state_t              : dispatcher FSM state encoding
//   is_muldiv()               : opcode/funct7 match helper
package pcpi_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } pcpi_state_t;

  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/pcpi_dispatch_if.sv
// pcpi_dispatch_if -- bundle of the core-side PCPI bus and the two
// coprocessor (mul/div) request/response buses.
//   master : core + coprocessors side (drives requests and responses)
//   slave  : the dispatcher
//
// Handshake: the core holds pcpi_valid high with a stable insn until it sees
// a one-cycle pcpi_ready (result) or pcpi_timeout (abort), or drops valid
// itself to abort. The dispatcher forwards valid to exactly one coprocessor,
// which answers with a one-cycle *_ready plus *_wr/*_rd in the same cycle.
interface pcpi_dispatch_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        pcpi_timeout;
  logic        mul_valid;
  logic        div_valid;
  logic        mul_wr;
  logic        div_wr;
  logic [31:0] mul_rd;
  logic [31:0] div_rd;
  logic        mul_ready;
  logic        div_ready;

  // rs1/rs2 go straight to the coprocessors, so the dispatcher never sees them.
  modport slave (
    input  pcpi_valid, pcpi_insn,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    output mul_valid, div_valid,
    input  mul_wr, div_wr, mul_rd, div_rd, mul_ready, div_ready
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    input  mul_valid, div_valid,
    output mul_wr, div_wr, mul_rd, div_rd, mul_ready, div_ready
  );
endinterface

// File: rtl/pcpi_dispatch.sv
// pcpi_dispatch -- claims RV32M instructions on the PCPI bus and forwards
// them to a multiplier or divider coprocessor, with a cycle timeout.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : pcpi_dispatch_if.slave (core bus + mul/div buses)
//   dbg_state   : current FSM state
// Params: TIMEOUT (2..255) ISSUE cycles before abort; ENABLE_MUL claims MUL class.
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  pcpi_dispatch_if.slave bus,
  output pcpi_state_t  dbg_state
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  pcpi_state_t state, state_nxt;
  logic          tgt_div;
  logic [TW-1:0] timer;
  logic          after_done;
  logic          cap_wr;
  logic [31:0]   cap_rd;

  logic match, match_div, claim, sel_ready, sel_wr, timer_last;
  logic [31:0] sel_rd;

  // Only opcode, funct7 and funct3[2] matter for the decode.
  logic unused_insn;
  assign unused_insn = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[13:7]};

  assign match     = bus.pcpi_valid && is_muldiv(bus.pcpi_insn[6:0], bus.pcpi_insn[31:25]);
  assign match_div = bus.pcpi_insn[14];
  // after_done blocks re-claiming the request the core still holds in the
  // cycle right after completion.
  assign claim     = match && !after_done && (match_div || ENABLE_MUL);

  assign sel_ready  = tgt_div ? bus.div_ready : bus.mul_ready;
  assign sel_wr     = tgt_div ? bus.div_wr    : bus.mul_wr;
  assign sel_rd     = tgt_div ? bus.div_rd    : bus.mul_rd;
  assign timer_last = (timer == TIMER_LAST);

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      after_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      after_done <= (state == ST_DONE);
    end
  end

  // Datapath registers: target, timer, captured result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tgt_div <= 1'b0;
      timer   <= '0;
      cap_wr  <= 1'b0;
      cap_rd  <= '0;
    end else begin
      if (state == ST_IDLE && claim) begin
        tgt_div <= match_div;
        timer   <= '0;
      end
      if (state == ST_ISSUE) begin
        timer <= timer + 1'b1;
        if (bus.pcpi_valid && sel_ready) begin
          cap_wr <= sel_wr;
          cap_rd <= sel_rd;
        end
      end
    end
  end

  // Next-state logic. A core abort takes precedence; a ready arriving in the
  // timeout cycle still completes the instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (claim) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (!bus.pcpi_valid)  state_nxt = ST_IDLE;
        else if (sel_ready)   state_nxt = ST_DONE;
        else if (timer_last)  state_nxt = ST_IDLE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.pcpi_wait    = 1'b0;
    bus.pcpi_ready   = 1'b0;
    bus.pcpi_wr      = 1'b0;
    bus.pcpi_rd      = '0;
    bus.pcpi_timeout = 1'b0;
    bus.mul_valid    = 1'b0;
    bus.div_valid    = 1'b0;
    case (state)
      ST_ISSUE: begin
        bus.pcpi_wait = 1'b1;
        if (tgt_div) bus.div_valid = bus.pcpi_valid;
        else         bus.mul_valid = bus.pcpi_valid && ENABLE_MUL;
        bus.pcpi_timeout = bus.pcpi_valid && !sel_ready && timer_last;
      end
      ST_DONE: begin
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = cap_wr;
        bus.pcpi_rd    = cap_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pcpi_dispatch.md
PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

Interface
REQ-001 Parameter TIMEOUT, default 64: ISSUE-state cycles allowed before abort; legal range 2..255.
REQ-002 Parameter ENABLE_MUL, default 1: when 0, MUL-class instructions are not claimed.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 pcpi_valid  input  1  core request valid.
REQ-006 pcpi_insn  input  32  instruction word; also routed externally, unmodified, to both coprocessors.
REQ-007 pcpi_rs1, pcpi_rs2  input  32 each  operands; routed externally to both coprocessors, not used internally.
REQ-008 pcpi_wr  output  1  result write-enable to core.
REQ-009 pcpi_rd  output  32  result to core.
REQ-010 pcpi_wait  output  1  claim/stall indication to core.
REQ-011 pcpi_ready  output  1  one-cycle completion strobe to core.
REQ-012 pcpi_timeout  output  1  one-cycle abort strobe.
REQ-013 mul_valid, div_valid  output  1 each  request valid to the multiplier / divider coprocessor.
REQ-014 mul_wr, div_wr  input  1 each  coprocessor write-enable.
REQ-015 mul_rd, div_rd  input  32 each  coprocessor result.
REQ-016 mul_ready, div_ready  input  1 each  coprocessor completion strobe.

Function
REQ-017 Match: pcpi_valid, insn[6:0]=0110011 and insn[31:25]=0000001; target is DIV when insn[14]=1, otherwise MUL.
REQ-018 States: IDLE, ISSUE, DONE; encoding is held in a registered state variable.
REQ-019 IDLE -> ISSUE on match when the previous state was not DONE and the target is enabled; target latched; timer cleared to 0.
REQ-020 ISSUE: selected *_valid equals pcpi_valid combinationally; the other *_valid is 0; pcpi_wait=1; timer increments each cycle.
REQ-021 ISSUE + selected ready: capture selected wr/rd into output registers; -> DONE.
REQ-022 DONE (exactly one cycle): pcpi_ready=1, pcpi_wr/pcpi_rd carry the captured values, both *_valid=0, pcpi_wait=0; -> IDLE.
REQ-023 Latency: pcpi_ready is asserted exactly one cycle after the coprocessor ready is sampled.
REQ-024 Outside DONE: pcpi_ready=0, pcpi_wr=0, pcpi_rd=0.
REQ-025 pcpi_wait=1 only in ISSUE; pcpi_timeout=0 except as stated in REQ-027.
REQ-026 ISSUE with pcpi_valid low (core abort): -> IDLE next cycle, with no ready and no timeout.
REQ-027 ISSUE with timer=TIMEOUT-1 and no selected ready: pcpi_timeout=1 for one cycle, -> IDLE, no ready.
REQ-028 Simultaneous selected ready and timeout condition: ready wins (-> DONE), no timeout.
REQ-029 ready from the non-selected coprocessor, or any ready in IDLE/DONE: ignored, no state or output change.
REQ-030 ENABLE_MUL=0: mul_valid constant 0; MUL-class match stays IDLE, pcpi_wait stays 0.
REQ-031 Non-matching instructions: no state change, all outputs 0.

Reset
REQ-032 resetn low at a clock edge: state IDLE, timer 0, pcpi_wr/pcpi_ready/pcpi_timeout 0, pcpi_rd 0; all *_valid and pcpi_wait are 0 from that edge.
REQ-033 Reset in ISSUE or DONE aborts silently; a pending coprocessor ready arriving after reset release is ignored.

Structure
REQ-034 Shared package pcpi_pkg holds OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001 and the state enum.
REQ-035 Single module; no sub-module; timer width is $clog2(TIMEOUT)+1.

Verification
REQ-036 DIVU insn 0x0220D0B3, rs1=100, rs2=7; div_ready with div_rd=14, div_wr=1 in cycle N -> pcpi_ready=1, pcpi_wr=1, pcpi_rd=14 in cycle N+1; mul_valid stays 0.
REQ-037 MUL insn 0x022080B3; mul_ready with mul_rd=0x2A -> pcpi_rd=0x2A one cycle later; with ENABLE_MUL=0 the same insn -> pcpi_wait stays 0 and mul_valid stays 0.
REQ-038 TIMEOUT=8, DIV issued, no ready -> pcpi_timeout pulse in the 8th ISSUE cycle, state IDLE; a div_ready two cycles later produces no pcpi_ready.
REQ-039 pcpi_valid dropped in the 3rd ISSUE cycle -> div_valid drops the same cycle, IDLE next cycle, no ready/timeout; then mul_ready pulse in IDLE -> ignored.
REQ-040 resetn low in ISSUE one cycle before div_ready -> no pcpi_ready; a new DIV issued after release completes normally.
REQ-041 Back-to-back: pcpi_valid held high through DONE -> no re-claim in the cycle after DONE; a fresh request afterwards is claimed.
